// File: rtl/gprc_writeback.sv
// gprc_writeback: XM23 general register file (R0-R7, R7 = PC) plus constant bank.
// Merges execute-result writes and memory-load writes onto one register write
// port. A one-entry holding buffer absorbs a load that collides with an
// execute write to a different register.
module gprc_writeback #(
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exe_valid,
   input  logic [2:0]            exe_dst,
   input  logic                  exe_byte,
   input  logic [15:0]           exe_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [2:0]            mem_dst,
   input  logic                  mem_byte,
   input  logic [15:0]           mem_data,
   input  logic                  pc_inc,
   input  logic                  pc_load,
   input  logic [15:0]           pc_target,
   output logic [1:0][7:0][15:0] gprc,
   output logic                  hold_valid,
   output logic [2:0]            hold_dst
);

   // Constant bank, index 0..7 = {0,1,2,4,8,16,32,FFFF}
   localparam logic [7:0][15:0] CONST_BANK = {16'hFFFF, 16'h0020, 16'h0010, 16'h0008,
                                              16'h0004, 16'h0002, 16'h0001, 16'h0000};

   // Byte writes replace only the low byte; word writes replace everything.
   function automatic logic [15:0] merge_write(input logic [15:0] old_val,
                                               input logic [15:0] new_data,
                                               input logic        is_byte);
      logic [15:0] res;
      if (is_byte) begin
         res = {old_val[15:8], new_data[7:0]};
      end else begin
         res = new_data;
      end
      return res;
   endfunction

   logic [7:0][15:0] regs_q, regs_d;
   logic             hold_valid_q, hold_valid_d;
   logic [2:0]       hold_dst_q, hold_dst_d;
   logic             hold_byte_q, hold_byte_d;
   logic [15:0]      hold_data_q, hold_data_d;

   logic             mem_acc_s;
   logic             old_valid_s;
   logic [2:0]       old_dst_s;
   logic             old_byte_s;
   logic [15:0]      old_data_s;
   logic             wr_en_s;
   logic [2:0]       wr_dst_s;
   logic [15:0]      wr_data_s;

   assign mem_ready  = ~hold_valid_q;
   assign hold_valid = hold_valid_q;
   assign hold_dst   = hold_dst_q;
   assign gprc       = {CONST_BANK, regs_q};

   // Pick the oldest pending non-exe write (held entry before fresh load) and
   // resolve it against the execute write onto the single write port.
   always_comb begin
      mem_acc_s    = mem_valid & ~hold_valid_q;
      old_valid_s  = 1'b0;
      old_dst_s    = 3'd0;
      old_byte_s   = 1'b0;
      old_data_s   = 16'h0000;
      wr_en_s      = 1'b0;
      wr_dst_s     = 3'd0;
      wr_data_s    = 16'h0000;
      hold_valid_d = 1'b0;
      hold_dst_d   = hold_dst_q;
      hold_byte_d  = hold_byte_q;
      hold_data_d  = hold_data_q;

      if (hold_valid_q) begin
         old_valid_s = 1'b1;
         old_dst_s   = hold_dst_q;
         old_byte_s  = hold_byte_q;
         old_data_s  = hold_data_q;
      end else if (mem_acc_s) begin
         old_valid_s = 1'b1;
         old_dst_s   = mem_dst;
         old_byte_s  = mem_byte;
         old_data_s  = mem_data;
      end else begin
         old_valid_s = 1'b0;
      end

      if (old_valid_s && exe_valid && (exe_dst == old_dst_s)) begin
         // Same destination: exe composed over the older write, one commit.
         wr_en_s   = 1'b1;
         wr_dst_s  = exe_dst;
         wr_data_s = merge_write(merge_write(regs_q[old_dst_s], old_data_s, old_byte_s),
                                 exe_data, exe_byte);
      end else if (old_valid_s && exe_valid) begin
         // Different destinations: exe wins the port, older entry waits in hold.
         wr_en_s      = 1'b1;
         wr_dst_s     = exe_dst;
         wr_data_s    = merge_write(regs_q[exe_dst], exe_data, exe_byte);
         hold_valid_d = 1'b1;
         hold_dst_d   = old_dst_s;
         hold_byte_d  = old_byte_s;
         hold_data_d  = old_data_s;
      end else if (old_valid_s) begin
         wr_en_s   = 1'b1;
         wr_dst_s  = old_dst_s;
         wr_data_s = merge_write(regs_q[old_dst_s], old_data_s, old_byte_s);
      end else if (exe_valid) begin
         wr_en_s   = 1'b1;
         wr_dst_s  = exe_dst;
         wr_data_s = merge_write(regs_q[exe_dst], exe_data, exe_byte);
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Next register-file state: general write, then R7 priority pc_load > write > pc_inc.
   always_comb begin
      regs_d = regs_q;
      if (wr_en_s) begin
         regs_d[wr_dst_s] = wr_data_s;
      end else begin
         regs_d = regs_q;
      end

      if (pc_load) begin
         regs_d[7] = pc_target;
      end else if (wr_en_s && (wr_dst_s == 3'd7)) begin
         regs_d[7] = wr_data_s;
      end else if (pc_inc) begin
         regs_d[7] = regs_q[7] + 16'd2;
      end else begin
         regs_d[7] = regs_q[7];
      end
   end

   // State registers with synchronous reset; reset discards any held entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q       <= {PC_RESET, 16'h0000, 16'h0000, 16'h0000,
                          16'h0000, 16'h0000, 16'h0000, 16'h0000};
         hold_valid_q <= 1'b0;
         hold_dst_q   <= 3'd0;
         hold_byte_q  <= 1'b0;
         hold_data_q  <= 16'h0000;
      end else begin
         regs_q       <= regs_d;
         hold_valid_q <= hold_valid_d;
         hold_dst_q   <= hold_dst_d;
         hold_byte_q  <= hold_byte_d;
         hold_data_q  <= hold_data_d;
      end
   end

endmodule

// File: doc/gprc_writeback.md
# gprc_writeback

Register-file writeback and program-counter owner for the XM23 pipeline. It holds the eight general registers (R0–R7, R7 = PC) and drives the constant bank, presenting both as the `gprc` array consumed by the execute units (including the move unit). It merges two single-register write sources onto one write port: execute results (ALU/move) and memory load data, with a one-entry holding buffer and a ready handshake for the load path.

## Interface
- PC_RESET, 16'h0000, value loaded into R7 on reset

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- exe_valid  in  1  execute-stage write request (always accepted)
- exe_dst  in  3  execute destination register
- exe_byte  in  1  1 = write [7:0] only, [15:8] preserved
- exe_data  in  16  execute write data
- mem_valid  in  1  load-data write request
- mem_ready  out  1  load path can accept; equals !hold_valid
- mem_dst  in  3  load destination register
- mem_byte  in  1  1 = byte write, as exe_byte
- mem_data  in  16  load write data
- pc_inc  in  1  R7 <= R7 + 2
- pc_load  in  1  R7 <= pc_target
- pc_target  in  16  branch target
- gprc  out  [1:0][7:0][15:0]  [0] = R0–R7 committed state; [1] = constants {0,1,2,4,8,16,32,16'hFFFF}, index 0..7
- hold_valid  out  1  holding buffer occupied
- hold_dst  out  3  destination of held entry (hazard detection)

## Operation
- Reset (rst=1 at edge): R0–R6 <= 0, R7 <= PC_RESET, hold_valid <= 0, hold contents <= 0. Consequently, mem_ready = 1 and hold_dst = 0 after reset. Reset overrides every other input that cycle, including an in-flight held entry, which is discarded.
- gprc[1] is constant and does not change during reset.
- Byte write merge: new = byte ? {old[15:8], data[7:0]} : data.
- Age order: the held entry is older than mem, and mem is older than exe. When multiple writes target the same register in one cycle, they are applied in age order onto the current value. The register is written once with the composed result.
- Per-cycle write selection (mem accepted = mem_valid && mem_ready):
  - hold empty, mem accepted, no exe: mem commits.
  - hold empty, mem accepted, exe to a different dst: exe commits; mem goes to the hold buffer (dst, byte, data).
  - hold empty, mem accepted, exe to the same dst: a single write of exe composed over mem; hold stays empty.
  - hold full, no exe: hold commits (drains); hold_valid <= 0.
  - hold full, exe to hold_dst: a single write of exe composed over hold; hold_valid <= 0.
  - hold full, exe to a different dst: exe commits; hold is retained.
  - mem_valid while mem_ready=0: not accepted; the source holds its request.
- R7 priority, highest first: rst, pc_load, register write to R7 (composition rules above), pc_inc.
  - pc_inc and a write to a non-R7 register in the same cycle both take effect.
  - R7 + 2 wraps modulo 2^16.
- pc_target and write data are taken whole; there are no alignment checks.

## Timing
- A commit at edge N is visible on gprc[0] after edge N; gprc is a registered output with no combinational bypass.
- Write latency: exe 1 cycle. mem 1 cycle direct, or 2+ cycles through the hold buffer; the held entry commits at the first edge with no exe_valid, or with an exe write to hold_dst.
- mem_ready is combinational from hold_valid only. It does not depend on exe_valid in the same cycle.
- hold_valid and hold_dst update at the edge; they are valid for hazard checks in the cycle after capture.
- Back-to-back exe writes with a pending hold keep the hold indefinitely. Starvation is acceptable because the pipeline stalls on hold_dst hazards.

## Test plan
- Reset: PC_RESET=16'h0100; assert rst 1 cycle → R0–R6 = 0, R7 = 16'h0100, hold_valid=0, mem_ready=1, gprc[1][6] = 16'h0020, gprc[1][7] = 16'hFFFF.
- Byte write: R3 = 16'hABCD; exe byte write R3 data 16'h0012 → R3 = 16'hAB12 next cycle. A word write of 16'h5555 → R3 = 16'h5555.
- Collision to different regs: exe R1 = 16'h1111 and mem R2 = 16'h2222 same cycle → R1 updated at edge 1, hold_valid=1, hold_dst=2, mem_ready=0. With exe idle next cycle → R2 = 16'h2222 at edge 2 and hold_valid=0.
- Collision to same reg: R4 = 16'h0000; mem word R4 = 16'h1234 plus exe byte R4 = 16'h0099 same cycle → R4 = 16'h1299, hold stays empty. With hold holding R5 = 16'hBEEF, exe word R5 = 16'h0001 → R5 = 16'h0001, hold cleared.
- PC: R7 = 16'hFFFE; pc_inc → 16'h0000. pc_load 16'h0200 together with pc_inc and exe R7 = 16'h0300 → R7 = 16'h0200.
- Reset mid-operation: hold full (R6 = 16'h7777 pending); rst asserted with exe_valid → hold discarded, R6 = 0, no exe write applied, mem_ready=1.
